// File: rtl/sprite_line_shifter_if.sv
// Line-load channel for sprite_line_shifter: valid/ready handshake carrying
// one packed line of pixels plus its per-line flip and scale attributes.
interface sprite_line_shifter_if #(
  parameter int PIX_W   = 3,
  parameter int DEPTH   = 16,
  parameter int SCALE_W = 2
);
  logic                     valid;
  logic                     ready;
  logic [PIX_W*DEPTH-1:0]   data;
  logic                     flip;
  logic [SCALE_W-1:0]       scale;

  // Producer side: offers lines, observes ready.
  modport master (output valid, data, flip, scale, input ready);
  // Shifter side: takes lines, reports shadow availability.
  modport slave  (input valid, data, flip, scale, output ready);
endinterface

// File: rtl/sprite_line_shifter.sv
// Double-buffered pixel serialiser. A line is accepted into a shadow slot,
// promoted to the active slot, and emitted one pixel per enable edge, each
// pixel repeated scale+1 times, optionally in reversed (flipped) order.
module sprite_line_shifter #(
  parameter int PIX_W   = 3,
  parameter int DEPTH   = 16,
  parameter int SCALE_W = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sprite_line_shifter_if.slave  ld,
  input  logic                  en,
  output logic [PIX_W-1:0]      pix_out,
  output logic                  pix_valid,
  output logic                  line_done,
  output logic                  busy
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                LINE_W   = PIX_W * DEPTH;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  // Shadow slot
  logic [LINE_W-1:0]   sh_data;
  logic                sh_flip;
  logic [SCALE_W-1:0]  sh_scale;
  logic                sh_full;

  // Active slot
  logic [LINE_W-1:0]   act_data;
  logic                act_flip;
  logic [SCALE_W-1:0]  act_scale;
  logic [IDX_W-1:0]    idx;
  logic [SCALE_W-1:0]  rep;
  logic                act_full;

  logic                accept;
  logic                last_emit;
  logic                promote;
  logic [IDX_W-1:0]    sel;
  logic [LINE_W-1:0]   act_shifted;
  logic [PIX_W-1:0]    field;

  assign ld.ready  = !sh_full;
  assign busy      = act_full || sh_full;
  assign accept    = ld.valid && !sh_full;
  assign last_emit = act_full && (idx == LAST_IDX) && (rep == act_scale);
  // Refill an empty active slot at once; otherwise hand over only on the
  // enable edge that carries the final repetition, so lines abut seamlessly.
  assign promote   = sh_full && (!act_full || (en && last_emit));

  // Pixel 0 sits in the top field, so shift the selected field up to the MSBs.
  assign sel         = act_flip ? (LAST_IDX - idx) : idx;
  assign act_shifted = act_data << (PIX_W * sel);
  assign field       = act_shifted[LINE_W-1 -: PIX_W];

  // Line payload registers: written on accept/promote, qualified by full flags.
  // NOTE: payload is deliberately left without reset; the full flags decide
  // whether it is ever looked at, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_data  <= ld.data;
      sh_flip  <= ld.flip;
      sh_scale <= ld.scale;
    end
    if (promote) begin
      act_data  <= sh_data;
      act_flip  <= sh_flip;
      act_scale <= sh_scale;
    end
  end

  // Slot occupancy and the active line's pixel/repeat position.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_full  <= 1'b0;
      act_full <= 1'b0;
      idx      <= '0;
      rep      <= '0;
    end else begin
      if (accept) begin
        sh_full <= 1'b1;
      end else if (promote) begin
        sh_full <= 1'b0;
      end

      if (promote) begin
        act_full <= 1'b1;
        idx      <= '0;
        rep      <= '0;
      end else if (en && act_full) begin
        if (rep == act_scale) begin
          rep <= '0;
          if (idx == LAST_IDX) begin
            act_full <= 1'b0;
            idx      <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end else begin
          rep <= rep + 1'b1;
        end
      end
    end
  end

  // Registered pixel outputs: update on enable edges, line_done is a pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
      line_done <= 1'b0;
    end else if (en) begin
      if (act_full) begin
        pix_out   <= field;
        pix_valid <= 1'b1;
        line_done <= last_emit;
      end else begin
        pix_out   <= '0;
        pix_valid <= 1'b0;
        line_done <= 1'b0;
      end
    end else begin
      line_done <= 1'b0;
    end
  end

endmodule
